// File: rtl/mem_wb_stage_if.sv
// Bundle between the EXE/MEM pipeline register (master) and the
// memory/write-back stage (slave).
interface mem_wb_stage_if;
    logic        wb_en_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic        freeze;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        addr_err;

    modport master (
        output wb_en_in, mem_read_in, mem_write_in, dest_in, alu_result, val_rm,
        input  freeze, wb_en, wb_dest, wb_value, addr_err
    );

    modport slave (
        input  wb_en_in, mem_read_in, mem_write_in, dest_in, alu_result, val_rm,
        output freeze, wb_en, wb_dest, wb_value, addr_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: word-addressed local data memory
// with a fixed number of wait states, pipeline freeze and the register
// file write-back triple.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepting a new instruction; memory ops freeze on entry
// WAIT   | counting wait states; access completes when r_cnt == 0
module mem_wb_stage #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic        HAS_WAIT = (WAIT_CYCLES > 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [DEPTH];
    logic        r_wb_en;
    logic [3:0]  r_wb_dest;
    logic [31:0] r_wb_value;
    logic        r_addr_err;

    logic             w_mem_op;
    logic [31:0]      w_off;
    logic             w_valid;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rdata;
    logic             w_freeze;

    // Address decode: word index relative to BASE, range and alignment check
    always_comb begin
        w_mem_op = bus.mem_read_in | bus.mem_write_in;
        w_off    = bus.alu_result - BASE;
        w_idx    = w_off[IDX_W+1:2];
        w_valid  = (bus.alu_result >= BASE)
                && ({2'b00, w_off[31:2]} < DEPTH_W)
                && (bus.alu_result[1:0] == 2'b00);
        w_rdata  = w_valid ? r_mem[w_idx] : 32'd0;
    end

    // Freeze is purely a function of state and current inputs, masked by reset
    always_comb begin
        w_freeze = 1'b0;
        if (!rst) begin
            if (r_state == S_IDLE) w_freeze = w_mem_op & HAS_WAIT;
            else                   w_freeze = (r_cnt != 4'd0);
        end
    end

    // Wait-state FSM with down-counter; completion happens when r_cnt hits 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_freeze) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
                    else               r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-back register: bubble on frozen edges, capture result on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en    <= 1'b0;
            r_wb_dest  <= 4'd0;
            r_wb_value <= 32'd0;
            r_addr_err <= 1'b0;
        end else if (w_freeze) begin
            r_wb_en    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_wb_en    <= bus.wb_en_in;
            r_wb_dest  <= bus.dest_in;
            r_wb_value <= bus.mem_read_in ? w_rdata : bus.alu_result;
            r_addr_err <= w_mem_op & ~w_valid;
        end
    end

    // Data memory: cleared on reset, written only on a valid completing store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else if (!w_freeze && bus.mem_write_in && w_valid) begin
            r_mem[w_idx] <= bus.val_rm;
        end
    end

    assign bus.freeze   = w_freeze;
    assign bus.wb_en    = r_wb_en;
    assign bus.wb_dest  = r_wb_dest;
    assign bus.wb_value = r_wb_value;
    assign bus.addr_err = r_addr_err;
endmodule
